// File: rtl/debounce_sync.sv
// Synchronizes a raw asynchronous level into the clk domain and debounces it,
// producing a clean level plus single-cycle rise/fall pulses.
module debounce_sync #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 4,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int             CNT_W       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LP_LAST   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_ZERO   = CNT_W'(0);
  localparam bit             LP_IMMEDIATE = (STABLE_CYCLES == 1);

  typedef enum logic [0:0] {
    ST_STABLE = 1'b0,
    ST_QUAL   = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_dout;
  logic                   w_dout_nxt;
  logic                   r_rise;
  logic                   w_rise_nxt;
  logic                   r_fall;
  logic                   w_fall_nxt;
  logic                   r_busy;

  // Synchronizer chain; only the last stage is ever looked at.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Debounce next-state: a sample matching dout always wins over qualification.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dout_nxt  = r_dout;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      ST_STABLE: begin
        if (w_s != r_dout) begin
          if (LP_IMMEDIATE) begin
            w_dout_nxt = w_s;
            w_rise_nxt = w_s;
            w_fall_nxt = ~w_s;
          end else begin
            w_cnt_nxt   = LP_ONE;
            w_state_nxt = ST_QUAL;
          end
        end else begin
          w_cnt_nxt   = LP_ZERO;
          w_state_nxt = ST_STABLE;
        end
      end
      ST_QUAL: begin
        if (w_s == r_dout) begin
          w_cnt_nxt   = LP_ZERO;
          w_state_nxt = ST_STABLE;
        end else if (r_cnt >= LP_LAST) begin
          w_dout_nxt  = w_s;
          w_rise_nxt  = w_s;
          w_fall_nxt  = ~w_s;
          w_cnt_nxt   = LP_ZERO;
          w_state_nxt = ST_STABLE;
        end else begin
          w_cnt_nxt   = r_cnt + LP_ONE;
          w_state_nxt = ST_QUAL;
        end
      end
      default: begin
        w_cnt_nxt   = LP_ZERO;
        w_state_nxt = ST_STABLE;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_STABLE;
      r_cnt   <= LP_ZERO;
      r_dout  <= RESET_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= w_dout_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_busy  <= (w_cnt_nxt != LP_ZERO);
    end
  end

  assign dout = r_dout;
  assign rise = r_rise;
  assign fall = r_fall;
  assign busy = r_busy;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed + randomized bench for debounce_sync: a default instance and a
// SYNC_STAGES=3 / STABLE_CYCLES=1 instance, both checked against a run-length model.
`timescale 1ns/100ps
module tb_debounce_sync;

  logic clk = 1'b0;
  logic reset;
  logic din_a, din_b;
  logic dout_a, rise_a, fall_a, busy_a;
  logic dout_b, rise_b, fall_b, busy_b;

  always #1 clk = ~clk;

  debounce_sync u_dut_a (
    .clk(clk), .reset(reset), .din(din_a),
    .dout(dout_a), .rise(rise_a), .fall(fall_a), .busy(busy_a)
  );

  debounce_sync #(.SYNC_STAGES(3), .STABLE_CYCLES(1), .RESET_LEVEL(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .din(din_b),
    .dout(dout_b), .rise(rise_b), .fall(fall_b), .busy(busy_b)
  );

  int tests = 0;
  int fails = 0;

  // Model: s seen at post-reset edge n is din captured at edge n-SYNC; dout
  // flips once s has differed from it on STABLE_CYCLES consecutive edges.
  int sync_n [2];
  int stab_n [2];
  int e_cnt  [2];
  int run    [2];
  bit dlog   [2][0:4095];
  bit m_dout [2];
  bit m_rise [2];
  bit m_fall [2];
  bit m_busy [2];

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      e_cnt[id] = 0; run[id] = 0;
      m_dout[id] = 1'b0; m_rise[id] = 1'b0; m_fall[id] = 1'b0; m_busy[id] = 1'b0;
    end
  endtask

  task automatic model_edge(input int id, input bit d);
    bit s;
    e_cnt[id]++;
    dlog[id][e_cnt[id]] = d;
    s = (e_cnt[id] > sync_n[id]) ? dlog[id][e_cnt[id] - sync_n[id]] : 1'b0;
    m_rise[id] = 1'b0;
    m_fall[id] = 1'b0;
    if (s != m_dout[id]) run[id]++;
    else run[id] = 0;
    if (run[id] == stab_n[id]) begin
      m_dout[id] = s;
      m_rise[id] = s;
      m_fall[id] = !s;
      run[id] = 0;
    end
    m_busy[id] = (run[id] != 0);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_dout_a"}, dout_a, m_dout[0]);
    check({tag, "_rise_a"}, rise_a, m_rise[0]);
    check({tag, "_fall_a"}, fall_a, m_fall[0]);
    check({tag, "_busy_a"}, busy_a, m_busy[0]);
    check({tag, "_dout_b"}, dout_b, m_dout[1]);
    check({tag, "_rise_b"}, rise_b, m_rise[1]);
    check({tag, "_fall_b"}, fall_b, m_fall[1]);
    check({tag, "_busy_b"}, busy_b, m_busy[1]);
    check({tag, "_both_a"}, rise_a & fall_a, 1'b0);
  endtask

  // One clock: model advances on the edge, outputs are checked on the falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    if (!reset) begin
      model_edge(0, din_a);
      model_edge(1, din_b);
    end
    @(negedge clk);
    check_all(tag);
  endtask

  int hold_a, hold_b;

  initial begin
    sync_n[0] = 2; stab_n[0] = 4;
    sync_n[1] = 3; stab_n[1] = 1;
    hold_a = 0; hold_b = 0;

    // 1. Reset hold with din=1, then release with din=0
    reset = 1'b1; din_a = 1'b1; din_b = 1'b1;
    model_reset();
    @(negedge clk);
    for (int e = 0; e < 3; e++) begin
      cycle("t1_hold");
      check("t1_dout_const", dout_a, 1'b0);
    end
    reset = 1'b0; din_a = 1'b0; din_b = 1'b0;
    for (int e = 0; e < 4; e++) cycle("t1_release");

    // 2. Clean rise
    din_a = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      cycle("t2");
      check("t2_dout", dout_a, e >= 6);
      check("t2_rise", rise_a, e == 6);
      check("t2_busy", busy_a, (e >= 3) && (e <= 5));
    end

    // 4. Clean fall right after the rise
    din_a = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      cycle("t4");
      check("t4_fall", fall_a, e == 6);
      check("t4_dout", dout_a, e < 6);
    end

    // 3. Glitch of three cycles is rejected
    din_a = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      if (e == 4) din_a = 1'b0;
      cycle("t3");
      check("t3_dout", dout_a, 1'b0);
      check("t3_rise", rise_a, 1'b0);
    end
    check("t3_busy_end", busy_a, 1'b0);

    // 5. Async reset between edges 4 and 5 of a rise
    din_a = 1'b1;
    for (int e = 1; e <= 4; e++) cycle("t5_pre");
    check("t5_busy_pre", busy_a, 1'b1);
    #0.2 reset = 1'b1;
    model_reset();
    #0.2;
    check("t5_dout_async", dout_a, 1'b0);
    check("t5_busy_async", busy_a, 1'b0);
    @(negedge clk);
    din_a = 1'b0;
    cycle("t5_in_reset");
    reset = 1'b0;
    for (int e = 0; e < 8; e++) begin
      cycle("t5_post");
      check("t5_rise", rise_a, 1'b0);
    end

    // 6. STABLE_CYCLES=1, SYNC_STAGES=3 instance
    din_b = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      cycle("t6");
      check("t6_dout", dout_b, e >= 4);
      check("t6_rise", rise_b, e == 4);
    end

    // Randomized bursts of varying length on both inputs
    for (int n = 0; n < 1500; n++) begin
      if (hold_a == 0) begin
        din_a  = 1'($urandom_range(0, 1));
        hold_a = $urandom_range(1, 7);
      end
      if (hold_b == 0) begin
        din_b  = 1'($urandom_range(0, 1));
        hold_b = $urandom_range(1, 3);
      end
      hold_a--;
      hold_b--;
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
